branch_comp_seq: RTL and testbench

Parametrised, multi-cycle branch comparator for the RV32 execute stage. Accepts two operands and a RISC-V branch `funct3` over a valid/ready handshake. Compares MSB-first, `CHUNK` bits per cycle, with early termination at the first differing chunk. Returns equal / less-than / taken flags over a second valid/ready handshake. It replaces the single-cycle comparator where timing on the full-width compare is critical, and adds signedness selection from `funct3`, a taken decision, illegal-encoding detection and flush.

---
 rtl/branch_pkg.sv | 39 +++
 rtl/branch_chunk_cmp.sv | 14 +
 rtl/branch_comp_seq.sv | 121 ++++++++++++
 tb/tb_branch_comp_seq.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the sequential branch comparator: funct3 encodings,
// FSM state type and small decode helpers.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } brcmp_state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        return f3[2:1] == 2'b01;
    endfunction

    function automatic logic f3_signed(input logic [2:0] f3);
        return f3[2:1] == 2'b10;
    endfunction

    function automatic logic f3_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (f3)
            F3_BEQ:           t = eq;
            F3_BNE:           t = !eq;
            F3_BLT, F3_BLTU:  t = lt;
            F3_BGE, F3_BGEU:  t = !lt;
            default:          t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice pair.
module branch_chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt
);

    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/branch_comp_seq.sv
// Multi-cycle RV32 branch comparator: MSB-first chunked compare with early
// termination, valid/ready on both sides, flush and illegal-funct3 reporting.
module branch_comp_seq
    import branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_eq,
    output logic            br_lt,
    output logic            br_taken,
    output logic            illegal
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [XLEN-1:0] MSB_MASK = XLEN'(1) << (XLEN - 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    brcmp_state_t    state, state_nxt;
    logic [XLEN-1:0] a_q, b_q;
    logic [2:0]      f3_q;
    logic [IDXW-1:0] idx;
    logic            chunk_eq, chunk_lt;
    logic            last_chunk;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign last_chunk = (idx == LAST_IDX);

    // Operands shift left each BUSY cycle, so the current chunk is always on top.
    branch_chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (a_q[XLEN-1 -: CHUNK]),
        .b  (b_q[XLEN-1 -: CHUNK]),
        .eq (chunk_eq),
        .lt (chunk_lt)
    );

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_nxt = BUSY;
                BUSY: if (f3_illegal(f3_q) || !chunk_eq || last_chunk) state_nxt = DONE;
                DONE: if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            idx      <= '0;
            br_eq    <= 1'b0;
            br_lt    <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else if (flush) begin
            idx      <= '0;
            br_eq    <= 1'b0;
            br_lt    <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Flipping the sign bit maps signed order onto unsigned order.
                        a_q      <= f3_signed(funct3) ? (data1 ^ MSB_MASK) : data1;
                        b_q      <= f3_signed(funct3) ? (data2 ^ MSB_MASK) : data2;
                        f3_q     <= funct3;
                        idx      <= '0;
                        br_eq    <= 1'b0;
                        br_lt    <= 1'b0;
                        br_taken <= 1'b0;
                        illegal  <= 1'b0;
                    end
                end
                BUSY: begin
                    if (f3_illegal(f3_q)) begin
                        illegal <= 1'b1;
                    end else if (!chunk_eq) begin
                        br_eq    <= 1'b0;
                        br_lt    <= chunk_lt;
                        br_taken <= f3_taken(f3_q, 1'b0, chunk_lt);
                    end else if (last_chunk) begin
                        br_eq    <= 1'b1;
                        br_lt    <= 1'b0;
                        br_taken <= f3_taken(f3_q, 1'b1, 1'b0);
                    end else begin
                        idx <= idx + IDXW'(1);
                        a_q <= a_q << CHUNK;
                        b_q <= b_q << CHUNK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_comp_seq.sv
// Self-checking bench for branch_comp_seq: directed scenarios plus randomized
// operations scored against a plain-arithmetic reference model.
module tb_branch_comp_seq;

    localparam int XLEN   = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = XLEN / CHUNK;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] data1 = '0;
    logic [XLEN-1:0] data2 = '0;
    logic [2:0]      funct3 = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            br_eq, br_lt, br_taken, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    branch_comp_seq #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1     (data1),
        .data2     (data2),
        .funct3    (funct3),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .br_eq     (br_eq),
        .br_lt     (br_lt),
        .br_taken  (br_taken),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    // Reference: outcome straight from RISC-V branch semantics; latency from the
    // position of the most-significant differing byte.
    task automatic model_op(input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] f3,
                            output logic eq, output logic lt, output logic tk,
                            output logic ill, output int lat);
        logic [31:0] x;
        ill = (f3 == 3'd2) || (f3 == 3'd3);
        eq  = 1'b0; lt = 1'b0; tk = 1'b0; lat = 1;
        if (!ill) begin
            eq = (d1 == d2);
            if (f3 == 3'd4 || f3 == 3'd5) lt = ($signed(d1) < $signed(d2));
            else                          lt = (d1 < d2);
            case (f3)
                3'd0:       tk = eq;
                3'd1:       tk = !eq;
                3'd4, 3'd6: tk = lt;
                default:    tk = !lt;
            endcase
            x   = d1 ^ d2;
            lat = NCHUNK;
            for (int c = NCHUNK - 1; c >= 0; c--)
                if (((x >> (CHUNK * (NCHUNK - 1 - c))) & 32'hFF) != 0) lat = c + 1;
        end
    endtask

    // Issues one request from IDLE (called #1 after a rising edge) and waits
    // for out_valid; lat = -1 if the result never appears.
    task automatic run_op(input logic [31:0] d1, input logic [31:0] d2, input logic [2:0] f3,
                          output int lat);
        data1 = d1; data2 = d2; funct3 = f3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 0; c <= NCHUNK + 4; c++) begin
            if (out_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        n_checks++;
        if ({br_eq, br_lt, br_taken, illegal} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000", {br_eq, br_lt, br_taken, illegal});
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  f3;
        logic [3:0]  flags;  // eq, lt, taken, illegal
        int          lat;
    } dir_t;

    task automatic test_directed();
        dir_t tbl[9];
        int lat;
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 4'b0110, 1};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 4'b0000, 1};
        tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 4'b0010, 1};
        tbl[3] = '{32'h12345678, 32'h12345678, 3'b000, 4'b1010, 4};
        tbl[4] = '{32'h12345678, 32'h12345678, 3'b001, 4'b1000, 4};
        tbl[5] = '{32'h00000010, 32'h00000011, 3'b001, 4'b0110, 4};
        tbl[6] = '{32'h00000005, 32'h00000005, 3'b010, 4'b0001, 1};
        tbl[7] = '{32'h80000000, 32'h7FFFFFFF, 3'b101, 4'b0100, 1};
        tbl[8] = '{32'h00010000, 32'h00020000, 3'b011, 4'b0001, 1};
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].d1, tbl[i].d2, tbl[i].f3, lat);
            n_checks++;
            if (lat !== tbl[i].lat) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, tbl[i].lat);
            end
            n_checks++;
            if ({br_eq, br_lt, br_taken, illegal} !== tbl[i].flags) begin
                n_fail++;
                $display("FAIL directed_flags[%0d]: got %b, required %b", i,
                         {br_eq, br_lt, br_taken, illegal}, tbl[i].flags);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [3:0] held;
        int bad;
        run_op(32'h00000010, 32'h00000011, 3'b001, lat);
        held = {br_eq, br_lt, br_taken, illegal};
        n_checks++;
        if (held !== 4'b0110) begin
            n_fail++;
            $display("FAIL bp_initial: got %b, required 0110", held);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {br_eq, br_lt, br_taken, illegal} !== 4'b0110) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
        end
        release_result();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int seen;
        int lat;
        data1 = 32'hCAFE0000; data2 = 32'hCAFE0000; funct3 = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        run_op(32'h12345678, 32'h12345678, 3'b000, lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || {br_eq, br_lt, br_taken, illegal} !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_done: out_valid=%b flags=%b, required 0 0000", out_valid,
                     {br_eq, br_lt, br_taken, illegal});
        end
        data1 = 32'h1; data2 = 32'h2; funct3 = 3'b100; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_blocks_accept: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        data1 = 32'hAAAA5555; data2 = 32'hAAAA5555; funct3 = 3'b001; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {br_eq, br_lt, br_taken, illegal} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b flags=%b, required 0 1 0000",
                     out_valid, in_ready, {br_eq, br_lt, br_taken, illegal});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL async_reset_after: %0d cycles not idle, required 0", seen);
        end
    endtask

    task automatic test_random();
        logic [31:0] d1, d2;
        logic [2:0]  f3;
        logic eq, lt, tk, ill;
        int exp_lat, lat, k;
        for (int i = 0; i < 300; i++) begin
            d1 = $urandom;
            d2 = d1;
            case ($urandom_range(0, 3))
                0: d2 = $urandom;
                1: begin
                    k  = $urandom_range(0, NCHUNK - 1);
                    d2 = d1 ^ (32'($urandom_range(1, 255)) << (CHUNK * k));
                end
                2: d2 = d1 ^ (32'h1 << $urandom_range(0, 31));
                default: ;
            endcase
            f3 = 3'($urandom_range(0, 7));
            model_op(d1, d2, f3, eq, lt, tk, ill, exp_lat);
            run_op(d1, d2, f3, lat);
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d, required %0d (d1=%h d2=%h f3=%b)",
                         i, lat, exp_lat, d1, d2, f3);
            end
            n_checks++;
            if ({br_eq, br_lt, br_taken, illegal} !== {eq, lt, tk, ill}) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: got %b, required %b (d1=%h d2=%h f3=%b)", i,
                         {br_eq, br_lt, br_taken, illegal}, {eq, lt, tk, ill}, d1, d2, f3);
            end
            for (int w = $urandom_range(0, 2); w > 0; w--) begin
                @(posedge clk); #1;
            end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
